// File: rtl/lock_code_checker.sv
// Combination checker: digit entry, grant/refuse, failure count, timed lockout.
// Optional LOCK_CODE_PROGRAM_EN allows reprogramming the code while unlocked.
module lock_code_checker #(
  parameter int DIGITS = 4,
  parameter int WIDTH = 5,
  parameter logic [DIGITS*WIDTH-1:0] CODE = 20'h90CEC,
  parameter int MAX_TRIES = 3,
  parameter int LOCKOUT_CYCLES = 100
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             EN,
  input  logic [WIDTH-1:0] digit_in,
  input  logic             enter,
  input  logic             clear,
  input  logic             relock,
  input  logic             prog,
  output logic             unlocked,
  output logic             fail,
  output logic             alarm,
  output logic [2:0]       digit_idx,
  output logic [3:0]       fail_cnt
);
  localparam int CW = DIGITS * WIDTH;
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, ENTRY, CHECK, UNLOCKED, FAILED, LOCKOUT
`ifdef LOCK_CODE_PROGRAM_EN
    , PROG
`endif
  } state_t;

  state_t          state;
  logic [3:0]      idx;
  logic            mism;
  logic [TW-1:0]   timer;
  logic [4:0]      fail_inc;
  logic            last;

  // Digit 0 lives in the most significant slot.
  function automatic logic [WIDTH-1:0] digit_of(
    input logic [CW-1:0] c,
    input logic [3:0]    i
  );
    digit_of = '0;
    for (int k = 0; k < DIGITS; k++)
      if (i == 4'(k))
        digit_of = c[(DIGITS-1-k)*WIDTH +: WIDTH];
  endfunction

`ifdef LOCK_CODE_PROGRAM_EN
  logic [CW-1:0] code_q;
  logic [CW-1:0] code_new;
  logic [CW-1:0] code_nxt;

  always_comb begin
    code_nxt = code_new;
    for (int k = 0; k < DIGITS; k++)
      if (idx == 4'(k))
        code_nxt[(DIGITS-1-k)*WIDTH +: WIDTH] = digit_in;
  end
`else
  logic [CW-1:0] code_q;
  logic          unused_prog;

  assign code_q = CODE;
  assign unused_prog = prog;
`endif

  assign fail_inc = {1'b0, fail_cnt} + 5'd1;
  assign last = (idx == 4'(DIGITS - 1));

  assign unlocked = (state == UNLOCKED)
`ifdef LOCK_CODE_PROGRAM_EN
                  | (state == PROG)
`endif
                  ;
  assign fail = (state == FAILED);
  assign alarm = (state == LOCKOUT);
  assign digit_idx = idx[2:0];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      idx      <= '0;
      mism     <= 1'b0;
      fail_cnt <= '0;
      timer    <= '0;
`ifdef LOCK_CODE_PROGRAM_EN
      code_q   <= CODE;
      code_new <= CODE;
`endif
    end else begin
      unique case (state)
        IDLE, ENTRY: begin
          if (EN && clear) begin
            state <= IDLE;
            idx   <= '0;
            mism  <= 1'b0;
          end else if (EN && enter) begin
            mism  <= mism | (digit_in != digit_of(code_q, idx));
            idx   <= idx + 4'd1;
            state <= last ? CHECK : ENTRY;
          end
        end
        CHECK: begin
          idx  <= '0;
          mism <= 1'b0;
          if (mism) begin
            state <= FAILED;
          end else begin
            state    <= UNLOCKED;
            fail_cnt <= '0;
          end
        end
        FAILED: begin
          if (fail_inc >= 5'(MAX_TRIES)) begin
            fail_cnt <= 4'(MAX_TRIES);
            timer    <= TW'(LOCKOUT_CYCLES - 1);
            state    <= LOCKOUT;
          end else begin
            fail_cnt <= fail_inc[3:0];
            state    <= IDLE;
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            state    <= IDLE;
            fail_cnt <= '0;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        UNLOCKED: begin
          if (EN && relock) begin
            state <= IDLE;
          end
`ifdef LOCK_CODE_PROGRAM_EN
          else if (EN && prog) begin
            state    <= PROG;
            idx      <= '0;
            code_new <= code_q;
          end
`endif
        end
`ifdef LOCK_CODE_PROGRAM_EN
        PROG: begin
          if (EN && clear) begin
            state <= UNLOCKED;
            idx   <= '0;
          end else if (EN && enter) begin
            code_new <= code_nxt;
            if (last) begin
              code_q <= code_nxt;
              idx    <= '0;
              state  <= IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lock_code_checker.sv
// Directed bench for lock_code_checker.
// Build with LOCK_CODE_PROGRAM_EN to cover reprogramming.
module tb_lock_code_checker;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       EN = 1'b1;
  logic [4:0] digit_in = '0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       relock = 1'b0;
  logic       prog = 1'b0;
  logic       unlocked;
  logic       fail;
  logic       alarm;
  logic [2:0] digit_idx;
  logic [3:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  lock_code_checker dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .EN(EN),
    .digit_in(digit_in),
    .enter(enter),
    .clear(clear),
    .relock(relock),
    .prog(prog),
    .unlocked(unlocked),
    .fail(fail),
    .alarm(alarm),
    .digit_idx(digit_idx),
    .fail_cnt(fail_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic key(input int d);
    digit_in = 5'(d);
    enter = 1'b1;
    step();
    enter = 1'b0;
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    key(a);
    key(b);
    key(c);
    key(d);
  endtask

  task automatic do_relock();
    relock = 1'b1;
    step();
    relock = 1'b0;
  endtask

  task automatic reset_pulse();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
  endtask

  task automatic wrong_try();
    code4(18, 3, 7, 13);
    step();
    step();
  endtask

  int cnt;

  initial begin
    step();
    step();
    RST_N = 1'b1;
    chk("rst_unlocked", unlocked, 0);
    chk("rst_fail", fail, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_idx", digit_idx, 0);
    chk("rst_fcnt", fail_cnt, 0);

    key(18); key(3); key(7);
    chk("idx3", digit_idx, 3);
    key(12);
    chk("lat_check", unlocked, 0);
    step();
    chk("unlock", unlocked, 1);
    chk("unlock_fcnt", fail_cnt, 0);
    chk("unlock_idx", digit_idx, 0);
    key(18);
    chk("unl_ign_enter", digit_idx, 0);
    do_relock();
    chk("relock", unlocked, 0);

    code4(18, 3, 7, 13);
    chk("w_lat", fail, 0);
    step();
    chk("w_fail", fail, 1);
    chk("w_fcnt_pre", fail_cnt, 0);
    step();
    chk("w_fail_end", fail, 0);
    chk("w_fcnt", fail_cnt, 1);
    chk("w_unl", unlocked, 0);
    code4(18, 3, 7, 12);
    step();
    chk("w_unlock", unlocked, 1);
    chk("w_fcnt_clr", fail_cnt, 0);
    do_relock();

    wrong_try();
    chk("t1_fcnt", fail_cnt, 1);
    wrong_try();
    chk("t2_fcnt", fail_cnt, 2);
    chk("t2_alarm", alarm, 0);
    code4(1, 1, 1, 1);
    step();
    chk("t3_fail", fail, 1);
    step();
    chk("t3_alarm", alarm, 1);
    chk("t3_fcnt", fail_cnt, 3);
    cnt = 0;
    while (alarm && cnt < 300) begin
      cnt++;
      enter = (cnt >= 10 && cnt < 14);
      relock = (cnt == 20);
      digit_in = (cnt == 10) ? 5'd18 : (cnt == 11) ? 5'd3 :
                 (cnt == 12) ? 5'd7 : 5'd12;
      step();
      if (cnt == 15)
        chk("lk_unl", unlocked, 0);
    end
    enter = 1'b0;
    relock = 1'b0;
    chk("alarm_len", cnt, 100);
    chk("post_lk_fcnt", fail_cnt, 0);
    chk("post_lk_idx", digit_idx, 0);
    chk("post_lk_unl", unlocked, 0);
    code4(18, 3, 7, 12);
    step();
    chk("post_lk_unlock", unlocked, 1);
    do_relock();

    key(18); key(3);
    clear = 1'b1;
    digit_in = 5'd7;
    enter = 1'b1;
    step();
    clear = 1'b0;
    enter = 1'b0;
    chk("clr_wins", digit_idx, 0);
    EN = 1'b0;
    key(18); key(3);
    chk("en0_idx", digit_idx, 0);
    EN = 1'b1;
    code4(18, 3, 7, 12);
    step();
    chk("clr_unlock", unlocked, 1);
    do_relock();

    key(18); key(3);
    chk("mid_idx", digit_idx, 2);
    reset_pulse();
    chk("mid_rst_idx", digit_idx, 0);
    key(7); key(12);
    chk("mid_rst_restart", digit_idx, 2);
    reset_pulse();

    wrong_try();
    wrong_try();
    wrong_try();
    step();
    chk("lk2_alarm", alarm, 1);
    reset_pulse();
    chk("lk_rst_alarm", alarm, 0);
    chk("lk_rst_fcnt", fail_cnt, 0);
    chk("lk_rst_idx", digit_idx, 0);
    chk("lk_rst_unl", unlocked, 0);
    code4(18, 3, 7, 12);
    step();
    chk("lk_rst_unlock", unlocked, 1);
    do_relock();

`ifdef LOCK_CODE_PROGRAM_EN
    code4(18, 3, 7, 12);
    step();
    prog = 1'b1;
    step();
    prog = 1'b0;
    chk("pg_unl", unlocked, 1);
    chk("pg_idx", digit_idx, 0);
    code4(1, 2, 3, 4);
    chk("pg_done", unlocked, 0);
    code4(18, 3, 7, 12);
    step();
    chk("pg_old_fail", fail, 1);
    step();
    code4(1, 2, 3, 4);
    step();
    chk("pg_new_unlock", unlocked, 1);
    prog = 1'b1;
    step();
    prog = 1'b0;
    key(9); key(9);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("pg_abort_unl", unlocked, 1);
    do_relock();
    code4(1, 2, 3, 4);
    step();
    chk("pg_abort_keep", unlocked, 1);
    reset_pulse();
    code4(18, 3, 7, 12);
    step();
    chk("pg_rst_default", unlocked, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lock_code_checker.md
# lock_code_checker

Receives the digit sequence produced by the lock counter, one digit per `enter` strobe, and compares it against a stored combination of `DIGITS` digits. It grants or refuses access, counts failed attempts, and enforces a timed lockout with an alarm after `MAX_TRIES` consecutive failures. It sits between the digit-selection counter and the door actuator/indicator logic of the encoded lock machine.

## Interface
- `DIGITS`, 4: digits per combination (2..8).
- `WIDTH`, 5: bits per digit; matches the counter's `numCounter` width.
- `CODE`, 20'h90CEC: reset combination, digit 0 in the MSBs (18, 3, 7, 12).
- `MAX_TRIES`, 3: consecutive failures that trigger lockout (1..15).
- `LOCKOUT_CYCLES`, 100: lockout duration in clocks (≥1).

- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: synchronous reset, active low.
- `EN` in 1: enables the `enter`, `clear` and `relock` inputs.
- `digit_in` in WIDTH: current digit value from the counter.
- `enter` in 1: single-cycle strobe that commits `digit_in`.
- `clear` in 1: abandons the entry in progress.
- `relock` in 1: returns from UNLOCKED to IDLE.
- `program` in 1: starts combination reprogramming (macro-dependent).
- `unlocked` out 1: access granted.
- `fail` out 1: one-cycle pulse on a wrong combination.
- `alarm` out 1: high throughout lockout.
- `digit_idx` out 3: number of digits entered so far.
- `fail_cnt` out 4: consecutive failure count.

## Operation
- States: IDLE, ENTRY, CHECK, UNLOCKED, FAIL, LOCKOUT, PROG.
- Reset: state IDLE, code register ← `CODE`, `digit_idx`=0, `fail_cnt`=0, lockout timer=0. All outputs reset to 0.
- `enter`, `clear`, `relock` and `program` act only when `EN`=1. When `EN`=0 the FSM holds, except that CHECK, FAIL and LOCKOUT always advance.
- IDLE/ENTRY:
  - Each `enter` compares `digit_in` with code digit[`digit_idx`], ORs the result into a sticky mismatch flag, and increments `digit_idx`.
  - The first `enter` moves IDLE→ENTRY.
  - The `enter` that makes `digit_idx`==DIGITS moves to CHECK.
  - No per-digit result is exposed.
- `clear` in ENTRY: go to IDLE, `digit_idx`=0, mismatch flag=0. If `clear` and `enter` arrive in the same cycle, `clear` wins.
- CHECK (1 cycle):
  - Mismatch flag = 0: go to UNLOCKED and set `fail_cnt`=0.
  - Mismatch flag = 1: go to FAIL.
  - `digit_idx` and the mismatch flag are cleared in either case.
- FAIL (1 cycle): `fail`=1 and `fail_cnt` increments. If the new count equals MAX_TRIES, go to LOCKOUT and load the timer with LOCKOUT_CYCLES-1. Otherwise go to IDLE.
- LOCKOUT: `alarm`=1 and all inputs are ignored. The timer decrements every cycle. When the timer is 0: go to IDLE, `fail_cnt`=0, `alarm`=0.
- UNLOCKED: `unlocked`=1. `relock` goes to IDLE. `enter` and `clear` are ignored. `program` is handled as described under Configuration.
- `fail_cnt` saturates at MAX_TRIES.
- `digit_idx` never exceeds DIGITS.

## Timing
- All outputs are registered and decoded from the state and counters.
- Last `enter` sampled at edge N → CHECK after edge N → `unlocked` or `fail` high after edge N+1. Latency from the final strobe to the result is 2 clocks.
- `fail` is high for exactly 1 cycle. LOCKOUT is entered at edge N+2.
- `alarm` is high for exactly LOCKOUT_CYCLES cycles.
- `digit_idx` updates on the edge that samples `enter`.
- `RST_N`=0 at any edge overrides everything, including mid-entry, lockout and PROG.

## Configuration
- Macro: `LOCK_CODE_PROGRAM_EN`.
- Defined:
  - `program` with `EN`=1 in UNLOCKED moves to PROG with `digit_idx`=0.
  - Each `enter` writes `digit_in` into code digit[`digit_idx`].
  - After the DIGITS-th write, go to IDLE; `unlocked` stays 1 during PROG.
  - `clear` in PROG aborts to UNLOCKED and restores the previous code.
  - The new code persists until reset.
- Undefined:
  - `program` is ignored and the PROG state is not present.
  - The code register is the constant `CODE`.

## Test plan
- Reset, `EN`=1, enter 18, 3, 7, 12 → `unlocked`=1 two clocks after the 4th strobe, `fail_cnt`=0; `relock` → IDLE, `unlocked`=0.
- Enter 18, 3, 7, 13 → `fail` pulses once, `fail_cnt`=1, `unlocked` stays 0; the next correct sequence unlocks and sets `fail_cnt`=0.
- Three wrong sequences → on the third, `alarm`=1 for exactly 100 cycles; a correct sequence during lockout is ignored; after lockout `fail_cnt`=0 and the correct code unlocks.
- Enter 18, 3, then `clear`+`enter` together, then 18, 3, 7, 12 → unlock (clear won, `digit_idx` restarted at 0). Strobes with `EN`=0 do not change `digit_idx`.
- `RST_N`=0 for one cycle after 2 digits, and separately during lockout → state IDLE, `digit_idx`=0, `alarm`=0, `fail_cnt`=0.
- With `LOCK_CODE_PROGRAM_EN`: unlock, `program`, enter 1, 2, 3, 4, then 18, 3, 7, 12 → `fail` pulses; 1, 2, 3, 4 → `unlocked`=1; reset → 18, 3, 7, 12 works again.
